mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Pipeline memory-access stage that sits directly upstream of memory_interface.
- Accepts load/store/pass-through ops from the execute stage.
- Checks alignment, then issues exactly one command pulse to memory_interface.
- Waits for output_valid or write_ready, bounded by a timeout, and stalls execute meanwhile.
- Presents results to writeback with a one-cycle registered handoff.

Parameters:
ADDR_W, 12, memory_interface address width
DATA_W, 32, data width
RD_W, 4, destination register index width
TIMEOUT, 64, max cycles in a wait state before a fault is raised (must be >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  stage accepts an op this cycle
ex_load  in  1  op is a load
ex_store  in  1  op is a store (ex_load and ex_store both high is treated as a load)
ex_address  in  ADDR_W  byte address
ex_store_data  in  DATA_W  store data, right-aligned
ex_word_type  in  2  2'b10 word, 2'b01 halfword, 2'b00 byte
ex_is_signed  in  1  sign-extend load result
ex_rd  in  RD_W  destination register
ex_result  in  DATA_W  ALU result for non-memory ops
mi_address  out  ADDR_W  to memory_interface.address
mi_data_in  out  DATA_W  to memory_interface.data_in
mi_data_out  in  DATA_W  from memory_interface.data_out
mi_load  out  1  load command pulse
mi_store  out  1  store command pulse
mi_is_signed  out  1  to memory_interface.is_signed
mi_word_type  out  2  to memory_interface.word_type
mi_busy  in  1  memory_interface busy
mi_write_ready  in  1  store completed
mi_output_valid  in  1  load data valid on mi_data_out
wb_valid  out  1  one-cycle result strobe
wb_we  out  1  write wb_data to wb_rd
wb_rd  out  RD_W  destination register
wb_data  out  DATA_W  result
wb_fault  out  1  misaligned access or timeout (with wb_valid, wb_we=0)

Behaviour:
- Reset (asynchronous): state IDLE; timer 0; all outputs 0 except ex_ready=1. Reset mid-transaction drops the pending op silently; no wb strobe is produced.
- States: IDLE, ISSUE, WAIT_LOAD, WAIT_STORE. ex_ready = (state==IDLE).
- IDLE, accept on ex_valid:
  - Non-memory op: next cycle wb_valid=1, wb_we=1, wb_data=ex_result, wb_rd=ex_rd. Stays IDLE.
  - Memory op, misaligned (word with addr[1:0]!=0, halfword with addr[0]!=0): next cycle wb_valid=1, wb_fault=1, wb_we=0. No mi command. Stays IDLE.
  - Aligned memory op: latch address, data, type, signed, rd and direction; go ISSUE.
- mi_address, mi_data_in, mi_word_type and mi_is_signed are driven from the latched registers and held stable from ISSUE until the return to IDLE.
- ISSUE: while mi_busy=1, mi_load and mi_store stay 0. On the first cycle with mi_busy=0, assert mi_load or mi_store for exactly that cycle. Next state is WAIT_LOAD or WAIT_STORE; timer cleared.
- mi_output_valid or mi_write_ready seen in ISSUE is ignored.
- WAIT_LOAD: on mi_output_valid, capture mi_data_out. Next cycle wb_valid=1, wb_we=1, wb_data=captured data unmodified (memory_interface performs extension). Go IDLE.
- WAIT_STORE: on mi_write_ready, next cycle wb_valid=1, wb_we=0, wb_data=0. Go IDLE.
- Timer increments each wait cycle. If it reaches TIMEOUT-1 without a response: wb_valid=1, wb_fault=1, wb_we=0; go IDLE. A response arriving in that same cycle wins over the timeout.
- wb_* outputs are registered; wb_valid and wb_fault are single-cycle pulses.
- Ideal latency: accept at cycle 0, mi command at cycle 1, wb at response+1.
- A new op is accepted in the same cycle the wb strobe of the previous op is emitted (state IDLE).

Decomposition:
- Package mem_pkg: WORD/HALFWORD/BYTE constants and state encodings, shared with memory_interface.
- One combinational sub-module, mem_align_check: inputs address low bits and word_type, output misaligned. It is reusable inside memory_interface.

Test Plan:
- ALU pass-through: ex_result=32'hDEADBEEF, rd=3 -> next cycle wb_valid=1, wb_we=1, wb_data=32'hDEADBEEF, wb_rd=3; ex_ready stays 1.
- Aligned word load at 12'h010, mi_busy=1 for 2 cycles, output_valid with 32'h12345678 two cycles after the pulse -> exactly one mi_load pulse, issued after busy drops; wb_data=32'h12345678; ex_ready low throughout.
- Halfword store at 12'h013 -> wb_fault=1, wb_valid=1 one cycle after accept; mi_store never asserted.
- Byte store at 12'h021, write_ready 3 cycles after the pulse -> mi_data_in/mi_word_type=2'b00 stable until done; wb_valid=1, wb_we=0.
- Load with no output_valid, TIMEOUT=8 -> wb_fault after 8 wait cycles; a following op is accepted immediately.
- Reset asserted in WAIT_LOAD -> all outputs 0 asynchronously, ex_ready=1 after release, no wb strobe; a late output_valid is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access types: access sizes and stage states.
// Also reused by memory_interface.
package mem_pkg;

  localparam logic [1:0] WORD     = 2'b10;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] BYTE     = 2'b00;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_LOAD  = 2'd2,
    WAIT_STORE = 2'd3
  } mem_state_e;

  function automatic logic is_mem_op(
    input logic load,
    input logic store
  );
    return load | store;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Command/response bus between the memory-access stage
// and memory_interface.
interface mem_access_stage_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              load;
  logic              store;
  logic              is_signed;
  logic [1:0]        word_type;
  logic              busy;
  logic              write_ready;
  logic              output_valid;

  modport master (
    output address, data_in, load, store,
    output is_signed, word_type,
    input  data_out, busy, write_ready,
    input  output_valid
  );

  modport slave (
    input  address, data_in, load, store,
    input  is_signed, word_type,
    output data_out, busy, write_ready,
    output output_valid
  );

endinterface

// File: rtl/mem_align_check.sv
// Flags word/halfword accesses whose address is not
// naturally aligned; bytes never fault.
module mem_align_check (
  input  logic [1:0] addr_lo,
  input  logic [1:0] word_type,
  output logic       misaligned
);

  import mem_pkg::*;

  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      (word_type == WORD):
        misaligned = |addr_lo;
      (word_type == HALFWORD):
        misaligned = addr_lo[0];
      default:
        misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: alignment check, one
// command pulse, bounded wait, registered writeback.
module mem_access_stage #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [ADDR_W-1:0] ex_address,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [1:0]        ex_word_type,
  input  logic              ex_is_signed,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  mem_access_stage_if.master mi,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fault
);

  import mem_pkg::*;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        wtype_q, wtype_d;
  logic              sgn_q, sgn_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              load_q, load_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_fault_q, wb_fault_d;

  logic misaligned;
  logic is_mem;
  logic resp;

  mem_align_check u_align (
    .addr_lo   (ex_address[1:0]),
    .word_type (ex_word_type),
    .misaligned(misaligned)
  );

  assign is_mem   = is_mem_op(ex_load, ex_store);
  assign ex_ready = (state_q == IDLE);

  // Responses only count in the matching wait state.
  assign resp = load_q ? mi.output_valid
                       : mi.write_ready;

  assign mi.address   = addr_q;
  assign mi.data_in   = data_q;
  assign mi.word_type = wtype_q;
  assign mi.is_signed = sgn_q;
  assign mi.load  = (state_q == ISSUE) & ~mi.busy
                  & load_q;
  assign mi.store = (state_q == ISSUE) & ~mi.busy
                  & ~load_q;

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_fault = wb_fault_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wtype_d    = wtype_q;
    sgn_d      = sgn_q;
    rd_d       = rd_q;
    load_d     = load_q;
    wb_valid_d = 1'b0;
    wb_fault_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          unique case (1'b1)
            !is_mem: begin
              wb_valid_d = 1'b1;
              wb_we_d    = 1'b1;
              wb_rd_d    = ex_rd;
              wb_data_d  = ex_result;
            end
            (is_mem && misaligned): begin
              wb_valid_d = 1'b1;
              wb_fault_d = 1'b1;
              wb_rd_d    = ex_rd;
              wb_data_d  = '0;
            end
            default: begin
              addr_d  = ex_address;
              data_d  = ex_store_data;
              wtype_d = ex_word_type;
              sgn_d   = ex_is_signed;
              rd_d    = ex_rd;
              load_d  = ex_load;
              state_d = ISSUE;
            end
          endcase
        end
      end
      ISSUE: begin
        if (!mi.busy) begin
          state_d = load_q ? WAIT_LOAD : WAIT_STORE;
          timer_d = '0;
        end
      end
      WAIT_LOAD, WAIT_STORE: begin
        if (resp) begin
          wb_valid_d = 1'b1;
          wb_we_d    = load_q;
          wb_rd_d    = rd_q;
          wb_data_d  = load_q ? mi.data_out : '0;
          state_d    = IDLE;
        end else if (timer_q == T_LAST) begin
          wb_valid_d = 1'b1;
          wb_fault_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wtype_q    <= '0;
      sgn_q      <= 1'b0;
      rd_q       <= '0;
      load_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wtype_q    <= wtype_d;
      sgn_q      <= sgn_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a
// transaction-level outcome/latency model.
module tb_mem_access_stage;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_ready;
  logic          ex_load, ex_store;
  logic [AW-1:0] ex_address;
  logic [DW-1:0] ex_store_data;
  logic [1:0]    ex_word_type;
  logic          ex_is_signed;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_result;
  logic          wb_valid, wb_we, wb_fault;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(
    .ADDR_W(AW), .DATA_W(DW)
  ) mi_if ();

  mem_access_stage #(
    .ADDR_W(AW), .DATA_W(DW),
    .RD_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_load      (ex_load),
    .ex_store     (ex_store),
    .ex_address   (ex_address),
    .ex_store_data(ex_store_data),
    .ex_word_type (ex_word_type),
    .ex_is_signed (ex_is_signed),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .mi           (mi_if.master),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_fault     (wb_fault)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mi_idle();
    mi_if.busy         = 1'b0;
    mi_if.output_valid = 1'b0;
    mi_if.write_ready  = 1'b0;
    mi_if.data_out     = '0;
  endtask

  // d = wait cycles before the response (0 = right after
  // the pulse); d >= TO means the response never lands.
  task automatic run_op(
    input logic          ld,
    input logic          st,
    input logic [AW-1:0] a,
    input logic [1:0]    wt,
    input logic          sg,
    input logic [RW-1:0] rd,
    input logic [DW-1:0] sd,
    input logic [DW-1:0] res,
    input logic [DW-1:0] rdata,
    input int            busy_n,
    input int            d
  );
    logic mem, mis, tmo, seen;
    int   exp_n, pulse_at, pulses;
    mem = ld | st;
    mis = mem && ((wt == 2'b10 && a[1:0] != 2'b00)
               || (wt == 2'b01 && a[0]));
    tmo = mem && !mis && (d > TO - 1);
    exp_n = (!mem || mis) ? 0
          : busy_n + 2 + ((d < TO - 1) ? d : TO - 1);
    chk("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid      = 1'b1;
    ex_load       = ld;
    ex_store      = st;
    ex_address    = a;
    ex_word_type  = wt;
    ex_is_signed  = sg;
    ex_rd         = rd;
    ex_store_data = sd;
    ex_result     = res;
    @(posedge clk);
    #1;
    ex_valid      = 1'b0;
    ex_address    = AW'($urandom);
    ex_store_data = $urandom;
    ex_word_type  = 2'($urandom);
    ex_rd         = RW'($urandom);
    pulse_at = -1;
    pulses   = 0;
    seen     = 1'b0;
    for (int n = 0; n < exp_n + 4 && !seen; n++) begin
      @(negedge clk);
      mi_if.busy = (pulse_at < 0) && (n < busy_n);
      mi_if.output_valid = 1'b0;
      mi_if.write_ready  = 1'b0;
      mi_if.data_out     = $urandom;
      if (pulse_at < 0 && n == 0) begin
        mi_if.output_valid = 1'b1;
        mi_if.write_ready  = 1'b1;
      end
      if (pulse_at >= 0 && n == pulse_at + 1 + d) begin
        if (ld) begin
          mi_if.output_valid = 1'b1;
          mi_if.data_out     = rdata;
        end else begin
          mi_if.write_ready = 1'b1;
        end
      end
      #1;
      if (mi_if.load | mi_if.store) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at = n;
          chk("pulse_cycle", 64'(n), 64'(busy_n));
          chk("mi_load_kind", 64'(mi_if.load),
              64'(ld));
          chk("mi_addr", 64'(mi_if.address), 64'(a));
          chk("mi_wtype", 64'(mi_if.word_type),
              64'(wt));
          chk("mi_data_in", 64'(mi_if.data_in),
              64'(sd));
          chk("mi_signed", 64'(mi_if.is_signed),
              64'(sg));
        end
      end
      if (wb_valid) begin
        seen = 1'b1;
        chk("wb_cycle", 64'(n), 64'(exp_n));
        chk("ex_ready_wb", 64'(ex_ready), 64'd1);
        if (!mem) begin
          chk("alu_we", 64'(wb_we), 64'd1);
          chk("alu_data", 64'(wb_data), 64'(res));
          chk("alu_rd", 64'(wb_rd), 64'(rd));
          chk("alu_fault", 64'(wb_fault), 64'd0);
        end else if (mis || tmo) begin
          chk("flt_fault", 64'(wb_fault), 64'd1);
          chk("flt_we", 64'(wb_we), 64'd0);
        end else if (ld) begin
          chk("ld_we", 64'(wb_we), 64'd1);
          chk("ld_data", 64'(wb_data), 64'(rdata));
          chk("ld_rd", 64'(wb_rd), 64'(rd));
          chk("ld_fault", 64'(wb_fault), 64'd0);
        end else begin
          chk("st_we", 64'(wb_we), 64'd0);
          chk("st_data", 64'(wb_data), 64'd0);
          chk("st_fault", 64'(wb_fault), 64'd0);
        end
      end else if (mem && !mis) begin
        chk("ex_ready_busy", 64'(ex_ready), 64'd0);
        if (pulse_at >= 0) begin
          chk("mi_addr_hold", 64'(mi_if.address),
              64'(a));
          chk("mi_wtype_hold", 64'(mi_if.word_type),
              64'(wt));
        end
      end
    end
    mi_idle();
    chk("wb_seen", 64'(seen), 64'd1);
    chk("mi_pulses", 64'(pulses),
        (mem && !mis) ? 64'd1 : 64'd0);
  endtask

  task automatic reset_mid_load();
    ex_valid     = 1'b1;
    ex_load      = 1'b1;
    ex_store     = 1'b0;
    ex_address   = 12'h080;
    ex_word_type = 2'b10;
    ex_rd        = 4'd7;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_mi_load", 64'(mi_if.load), 64'd0);
    chk("rst_mi_addr", 64'(mi_if.address), 64'd0);
    chk("rst_mi_wtype", 64'(mi_if.word_type), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mi_if.output_valid = 1'b1;
    mi_if.data_out     = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("late_ov_wb", 64'(wb_valid), 64'd0);
      chk("late_ov_ready", 64'(ex_ready), 64'd1);
    end
    mi_idle();
  endtask

  initial begin
    logic          ld, st;
    logic [1:0]    wt;
    int            kind;
    reset         = 1'b1;
    ex_valid      = 1'b0;
    ex_load       = 1'b0;
    ex_store      = 1'b0;
    ex_address    = '0;
    ex_store_data = '0;
    ex_word_type  = '0;
    ex_is_signed  = 1'b0;
    ex_rd         = '0;
    ex_result     = '0;
    mi_idle();
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ex_ready), 64'd1);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_fault", 64'(wb_fault), 64'd0);
    chk("rst_data", 64'(wb_data), 64'd0);
    chk("rst_load", 64'(mi_if.load), 64'd0);
    chk("rst_store", 64'(mi_if.store), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 0, 12'h000, 2'b10, 0, 4'd3, 32'h0,
           32'hDEADBEEF, 32'h0, 0, 0);
    run_op(1, 0, 12'h010, 2'b10, 0, 4'd5, 32'h0,
           32'h0, 32'h12345678, 2, 1);
    run_op(0, 1, 12'h013, 2'b01, 0, 4'd2, 32'hBEEF,
           32'h0, 32'h0, 0, 0);
    run_op(0, 1, 12'h021, 2'b00, 0, 4'd1, 32'hA5,
           32'h0, 32'h0, 0, 2);
    run_op(1, 0, 12'h040, 2'b10, 1, 4'd9, 32'h0,
           32'h0, 32'h0, 1, 1000);
    run_op(0, 0, 12'h000, 2'b00, 0, 4'd4, 32'h0,
           32'h11112222, 32'h0, 0, 0);
    run_op(1, 1, 12'h102, 2'b01, 1, 4'd6, 32'h77,
           32'h0, 32'hFFFF8001, 0, TO - 1);
    run_op(0, 1, 12'h104, 2'b10, 0, 4'd8, 32'h99,
           32'h0, 32'h0, 3, TO);
    reset_mid_load();

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      ld   = (kind == 1) || (kind == 3);
      st   = (kind == 2) || (kind == 3);
      wt   = 2'($urandom_range(0, 2));
      run_op(ld, st, AW'($urandom), wt,
             1'($urandom), RW'($urandom), $urandom,
             $urandom, $urandom,
             $urandom_range(0, 3),
             $urandom_range(0, TO + 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
